gpio_in_debounce: RTL and testbench

GPIO_IN_DEBOUNCE -- requirements
Module: gpio_in_debounce

---
 rtl/gpio_in_debounce_if.sv | 21 ++
 rtl/gpio_in_debounce.sv | 65 ++++++
 tb/tb_gpio_in_debounce.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gpio_in_debounce_if.sv
// Pin-side bundle for the GPIO input conditioner: raw pads and bypass in,
// filtered levels and change strobes out.
interface gpio_in_debounce_if #(
    parameter int IO_NUM = 8
);
    logic [IO_NUM-1:0] PAD_IN;
    logic [IO_NUM-1:0] BYPASS;
    logic [IO_NUM-1:0] GPIO_IN;
    logic [IO_NUM-1:0] EDGE_PULSE;
    logic              CHANGE_OR;

    modport master (
        output PAD_IN, BYPASS,
        input  GPIO_IN, EDGE_PULSE, CHANGE_OR
    );

    modport slave (
        input  PAD_IN, BYPASS,
        output GPIO_IN, EDGE_PULSE, CHANGE_OR
    );
endinterface

// File: rtl/gpio_in_debounce.sv
// Per-pin 2-flop synchroniser plus saturating-count debouncer feeding CoreGPIO,
// with registered per-pin change strobes and their OR.
module gpio_in_debounce #(
    parameter int IO_NUM    = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    gpio_in_debounce_if.slave io
);
    localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);

    logic [IO_NUM-1:0]      s1_q, s1_d;
    logic [IO_NUM-1:0]      s2_q, s2_d;
    logic [IO_NUM-1:0]      gpio_q, gpio_d;
    logic [IO_NUM-1:0]      edge_q, edge_d;
    logic [IO_NUM-1:0][7:0] cnt_q, cnt_d;
    logic                   change_q, change_d;

    always_comb begin
        s1_d   = io.PAD_IN;
        s2_d   = s1_q;
        gpio_d = gpio_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < IO_NUM; i++) begin
            if (io.BYPASS[i]) begin
                gpio_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else if (s2_q[i] == gpio_q[i]) begin
                // agreement with the accepted level discards any partial count
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_MAX) begin
                gpio_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
        // strobe and OR come from next-state so they line up with the GPIO_IN change
        edge_d   = gpio_d ^ gpio_q;
        change_d = |edge_d;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            s1_q     <= '0;
            s2_q     <= '0;
            gpio_q   <= '0;
            edge_q   <= '0;
            cnt_q    <= '0;
            change_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            gpio_q   <= gpio_d;
            edge_q   <= edge_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
        end
    end

    assign io.GPIO_IN    = gpio_q;
    assign io.EDGE_PULSE = edge_q;
    assign io.CHANGE_OR  = change_q;
endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce: a DB_CYCLES=4 instance driven from a
// vector table plus corner sequences, and a DB_CYCLES=1 instance.
`timescale 1ns/100ps
module tb_gpio_in_debounce;
    logic PCLK;
    logic PRESETN;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    gpio_in_debounce_if #(.IO_NUM(8)) io4 ();
    gpio_in_debounce_if #(.IO_NUM(8)) io1 ();

    gpio_in_debounce #(.IO_NUM(8), .DB_CYCLES(4)) dut4 (.PCLK(PCLK), .PRESETN(PRESETN), .io(io4.slave));
    gpio_in_debounce #(.IO_NUM(8), .DB_CYCLES(1)) dut1 (.PCLK(PCLK), .PRESETN(PRESETN), .io(io1.slave));

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic       rst;
        logic [7:0] pad;
        logic [7:0] byp;
        logic [7:0] gpio;
        logic [7:0] epls;
        logic       orv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [7:0] p, logic [7:0] b,
                                logic [7:0] g, logic [7:0] e, logic o);
        vec_t v;
        v.rst = r; v.pad = p; v.byp = b; v.gpio = g; v.epls = e; v.orv = o;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk4(string nm, logic [7:0] g, logic [7:0] e, logic o);
        chk({nm, " gpio"}, 32'(io4.GPIO_IN), 32'(g));
        chk({nm, " edge"}, 32'(io4.EDGE_PULSE), 32'(e));
        chk({nm, " or"}, 32'(io4.CHANGE_OR), 32'(o));
    endtask

    // 1 ns reset pulse, outputs must clear without a clock edge
    task automatic pulse_rst();
        PRESETN = 1'b0;
        #0.5;
        chk4("rst", 8'h00, 8'h00, 1'b0);
        chk("rst dut1 gpio", 32'(io1.GPIO_IN), 32'h0);
        chk("rst cnt", 32'(dut4.cnt_q), 32'h0);
        #0.5;
        PRESETN = 1'b1;
    endtask

    // Strobe must never hold two cycles on one bit; GPIO_IN never X out of reset.
    logic [7:0] prev4, prev1;
    always @(negedge PCLK) begin
        if (!PRESETN) begin
            prev4 = '0;
            prev1 = '0;
        end else begin
            chk("mon4 double pulse", 32'(io4.EDGE_PULSE & prev4), 32'h0);
            chk("mon1 double pulse", 32'(io1.EDGE_PULSE & prev1), 32'h0);
            chk("mon gpio X", 32'($isunknown({io4.GPIO_IN, io1.GPIO_IN})), 32'h0);
            prev4 = io4.EDGE_PULSE;
            prev1 = io1.EDGE_PULSE;
        end
    end

    initial begin
        PRESETN    = 1'b0;
        io4.PAD_IN = '0; io4.BYPASS = '0;
        io1.PAD_IN = '0; io1.BYPASS = '0;
        prev4 = '0; prev1 = '0;
        #2;
        chk4("reset state", 8'h00, 8'h00, 1'b0);
        #1;
        PRESETN = 1'b1;
        step();

        // debounce rise then fall on bit 0: change lands on edge 6
        vecs.push_back(mk(1, 8'h01, 8'h00, 8'h00, 8'h00, 0));
        for (int i = 2; i <= 5; i++) vecs.push_back(mk(0, 8'h01, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'h01, 8'h00, 8'h01, 8'h01, 1));
        vecs.push_back(mk(0, 8'h01, 8'h00, 8'h01, 8'h00, 0));
        vecs.push_back(mk(0, 8'h01, 8'h00, 8'h01, 8'h00, 0));
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 8'h00, 8'h00, 8'h01, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 8'h01, 1));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        // full bypass: A5 at edge 3, then 5A flips every bit
        vecs.push_back(mk(1, 8'hA5, 8'hFF, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'hA5, 8'hFF, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'hA5, 8'hFF, 8'hA5, 8'hA5, 1));
        vecs.push_back(mk(0, 8'hA5, 8'hFF, 8'hA5, 8'h00, 0));
        vecs.push_back(mk(0, 8'h5A, 8'hFF, 8'hA5, 8'h00, 0));
        vecs.push_back(mk(0, 8'h5A, 8'hFF, 8'hA5, 8'h00, 0));
        vecs.push_back(mk(0, 8'h5A, 8'hFF, 8'h5A, 8'hFF, 1));
        vecs.push_back(mk(0, 8'h5A, 8'hFF, 8'h5A, 8'h00, 0));
        // four bits debounced together
        vecs.push_back(mk(1, 8'h0F, 8'h00, 8'h00, 8'h00, 0));
        for (int i = 2; i <= 5; i++) vecs.push_back(mk(0, 8'h0F, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'h0F, 8'h00, 8'h0F, 8'h0F, 1));
        vecs.push_back(mk(0, 8'h0F, 8'h00, 8'h0F, 8'h00, 0));
        // mixed: bit 4 bypassed, bit 0 debounced
        vecs.push_back(mk(1, 8'h11, 8'h10, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'h11, 8'h10, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'h11, 8'h10, 8'h10, 8'h10, 1));
        vecs.push_back(mk(0, 8'h11, 8'h10, 8'h10, 8'h00, 0));
        vecs.push_back(mk(0, 8'h11, 8'h10, 8'h10, 8'h00, 0));
        vecs.push_back(mk(0, 8'h11, 8'h10, 8'h11, 8'h01, 1));
        vecs.push_back(mk(0, 8'h11, 8'h10, 8'h11, 8'h00, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            io4.PAD_IN = vecs[k].pad;
            io4.BYPASS = vecs[k].byp;
            if (vecs[k].rst) pulse_rst();
            step();
            chk4($sformatf("vec%0d", k), vecs[k].gpio, vecs[k].epls, vecs[k].orv);
        end

        // 3-sample glitch on bit 1 never reaches GPIO_IN and leaves cnt at 0
        io4.PAD_IN = 8'h00; io4.BYPASS = 8'h00;
        pulse_rst();
        io4.PAD_IN = 8'h02;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 3) io4.PAD_IN = 8'h00;
            chk4($sformatf("glitch e%0d", k), 8'h00, 8'h00, 1'b0);
            if (k == 5) chk("glitch cnt peak", 32'(dut4.cnt_q[1]), 32'd3);
            if (k == 6) chk("glitch cnt clear", 32'(dut4.cnt_q[1]), 32'd0);
        end

        // reset mid-count on bit 2 with bit 0 already high, then pins still held
        pulse_rst();
        io4.PAD_IN = 8'h01;
        for (int k = 1; k <= 6; k++) step();
        chk("pre-rst gpio", 32'(io4.GPIO_IN), 32'h01);
        io4.PAD_IN = 8'h05;
        for (int k = 1; k <= 4; k++) step();
        chk("pre-rst cnt2", 32'(dut4.cnt_q[2]), 32'd2);
        chk("pre-rst gpio2", 32'(io4.GPIO_IN), 32'h01);
        pulse_rst();
        for (int k = 1; k <= 5; k++) begin
            step();
            chk4($sformatf("post-rst e%0d", k), 8'h00, 8'h00, 1'b0);
        end
        step();
        chk4("post-rst e6", 8'h05, 8'h05, 1'b1);
        step();
        chk4("post-rst e7", 8'h05, 8'h00, 1'b0);

        // bypass 0->1 mid-count, then 1->0 restarts counting from zero
        io4.PAD_IN = 8'h00;
        pulse_rst();
        io4.PAD_IN = 8'h08;
        for (int k = 1; k <= 4; k++) step();
        chk("byp cnt mid", 32'(dut4.cnt_q[3]), 32'd2);
        chk4("byp pre", 8'h00, 8'h00, 1'b0);
        io4.BYPASS = 8'h08;
        step();
        chk4("byp toggle", 8'h08, 8'h08, 1'b1);
        chk("byp cnt clr", 32'(dut4.cnt_q[3]), 32'd0);
        io4.BYPASS = 8'h00;
        io4.PAD_IN = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("unbyp e%0d gpio", k), 32'(io4.GPIO_IN), 32'h08);
            if (k == 3) chk("unbyp cnt start", 32'(dut4.cnt_q[3]), 32'd1);
        end
        step();
        chk4("unbyp e6", 8'h00, 8'h08, 1'b1);

        // DB_CYCLES=1: bit 7 falls at edge 3, bit 3 switched to bypass mid-flight
        io4.PAD_IN = 8'h00;
        pulse_rst();
        io1.PAD_IN = 8'h80;
        for (int k = 1; k <= 3; k++) step();
        chk("db1 rise gpio", 32'(io1.GPIO_IN), 32'h80);
        chk("db1 rise edge", 32'(io1.EDGE_PULSE), 32'h80);
        step();
        chk("db1 rise clr", 32'(io1.EDGE_PULSE), 32'h00);
        io1.PAD_IN = 8'h08;
        step();
        chk("db1 e1 gpio", 32'(io1.GPIO_IN), 32'h80);
        step();
        chk("db1 e2 gpio", 32'(io1.GPIO_IN), 32'h80);
        io1.BYPASS = 8'h08;
        step();
        chk("db1 e3 gpio", 32'(io1.GPIO_IN), 32'h08);
        chk("db1 e3 edge", 32'(io1.EDGE_PULSE), 32'h88);
        chk("db1 e3 or", 32'(io1.CHANGE_OR), 32'h1);
        chk("db1 e3 cnt3", 32'(dut1.cnt_q[3]), 32'd0);
        step();
        chk("db1 e4 edge", 32'(io1.EDGE_PULSE), 32'h00);
        chk("db1 e4 or", 32'(io1.CHANGE_OR), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
